// File: rtl/max_unpool_2x2.sv
// max_unpool_2x2: streaming 2x2 max-unpooling, one pooled row in, two full-resolution rows out
module max_unpool_2x2 #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [1:0]               in_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_row,
  output logic                     out_last
);
  localparam int PW  = OUT_W / 2;
  localparam int PCW = PW > 1 ? $clog2(PW) : 1;
  localparam int XCW = $clog2(OUT_W);
  typedef enum logic [1:0] {FILL, EMIT_TOP, EMIT_BOT} state_t;
  state_t r_state, w_next;
  logic signed [DATA_W-1:0] r_data [PW];
  logic [1:0]               r_idx  [PW];
  logic [PCW-1:0]           r_pcnt;
  logic [XCW-1:0]           r_xcnt;
  logic [PCW-1:0]           w_p;
  logic                     w_in_fire, w_out_fire, w_pcnt_end, w_xcnt_end, w_bot, w_match;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_pcnt_end = r_pcnt == PCW'(PW - 1);
  assign w_xcnt_end = r_xcnt == XCW'(OUT_W - 1);
  assign w_bot      = r_state == EMIT_BOT;
  assign w_p        = PCW'(r_xcnt >> 1);
  assign w_match    = r_idx[w_p] == {w_bot, r_xcnt[0]};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_next;
  // fill and emit position counters, each wrapping at the end of its row
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pcnt <= '0;
      r_xcnt <= '0;
    end else begin
      if (w_in_fire)  r_pcnt <= w_pcnt_end ? '0 : r_pcnt + 1'b1;
      if (w_out_fire) r_xcnt <= w_xcnt_end ? '0 : r_xcnt + 1'b1;
    end
  // pooled row buffer; contents are only read after being rewritten, so no reset
  always_ff @(posedge clk)
    if (w_in_fire) begin
      r_data[r_pcnt] <= in_data;
      r_idx[r_pcnt]  <= in_idx;
    end
  // next state: fill a whole pooled row, then emit top and bottom output rows
  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:     w_next = (w_in_fire && w_pcnt_end) ? EMIT_TOP : FILL;
      EMIT_TOP: w_next = (w_out_fire && w_xcnt_end) ? EMIT_BOT : EMIT_TOP;
      EMIT_BOT: w_next = (w_out_fire && w_xcnt_end) ? FILL : EMIT_BOT;
      default:  w_next = FILL;
    endcase
  end
  // outputs: pixel carries the pooled value only at its argmax position, else zero
  always_comb begin
    in_ready  = r_state == FILL;
    out_valid = r_state != FILL;
    out_row   = w_bot;
    out_last  = out_valid && w_xcnt_end;
    out_data  = (out_valid && w_match) ? r_data[w_p] : '0;
  end
endmodule
